lamp_fpu_sqrt_iter: RTL and testbench



---
 rtl/lamp_fpu_sqrt_iter.sv | 191 +++++++++++++++++++
 tb/tb_lamp_fpu_sqrt_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_fpu_sqrt_iter.sv
// Iterative radix-2 restoring square-root unit for the lampFPU datapath.
// Produces one root bit per cycle and hands {hidden, fraction, G, R, S} to the rounding stage.
module lamp_fpu_sqrt_iter #(
  parameter int unsigned E_DW = 8,
  parameter int unsigned F_DW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              signum_op_i,
  input  logic [E_DW-1:0]   extExp_op_i,
  input  logic [F_DW:0]     extMant_op_i,
  input  logic              isInf_op_i,
  input  logic              isZero_op_i,
  input  logic              isSNAN_op_i,
  input  logic              isQNAN_op_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              s_res_o,
  output logic [E_DW-1:0]   e_res_o,
  output logic [F_DW+3:0]   f_res_o,
  output logic              isToRound_o,
  output logic              invalid_o
);

  localparam int unsigned N    = F_DW + 3;
  localparam int unsigned RW   = 2 * F_DW + 6;
  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned BIAS = 2 ** (E_DW - 1) - 1;
  localparam logic [E_DW:0] BIAS_W = (E_DW + 1)'(BIAS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rad_q, rad_d;
  logic [N+1:0]      rem_q, rem_d;
  logic [N-1:0]      root_q, root_d;
  logic [E_DW-1:0]   exp_q, exp_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              s_q, s_d;
  logic [E_DW-1:0]   e_q, e_d;
  logic [F_DW+3:0]   f_q, f_d;
  logic              rnd_q, rnd_d;
  logic              inv_q, inv_d;

  logic              odd;
  logic [RW-1:0]     rad_ext;
  logic [RW-1:0]     rad_init;
  logic [N+3:0]      lhs;
  logic [N+3:0]      trial;
  logic              step_ok;
  logic [N+1:0]      rem_step;
  logic [N-1:0]      root_step;
  logic              is_special;

  // One recurrence step: trial = 4*rem + next radicand pair - (4*Q + 1); restore when negative.
  always_comb begin
    odd        = ~extExp_op_i[0];
    rad_ext    = {{(RW - F_DW - 1){1'b0}}, extMant_op_i};
    rad_init   = odd ? (rad_ext << (F_DW + 5)) : (rad_ext << (F_DW + 4));
    lhs        = {rem_q, rad_q[RW-1 -: 2]};
    trial      = lhs - {2'b00, root_q, 2'b01};
    step_ok    = ~trial[N+3];
    rem_step   = step_ok ? (N + 2)'(trial) : (N + 2)'(lhs);
    root_step  = {root_q[N-2:0], step_ok};
    is_special = isSNAN_op_i | isQNAN_op_i | isZero_op_i | signum_op_i | isInf_op_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    ready_d = ready_q;
    valid_d = valid_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    rnd_d   = rnd_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          ready_d = 1'b0;
          if (is_special) begin
            state_d = DONE;
            valid_d = 1'b1;
            rnd_d   = 1'b0;
            s_d     = 1'b0;
            e_d     = {E_DW{1'b1}};
            f_d     = {2'b11, {(F_DW + 2){1'b0}}};
            inv_d   = 1'b1;
            if (isSNAN_op_i || isQNAN_op_i) begin
              inv_d = isSNAN_op_i;
            end else if (isZero_op_i) begin
              s_d   = signum_op_i;
              e_d   = '0;
              f_d   = '0;
              inv_d = 1'b0;
            end else if (!signum_op_i) begin
              f_d   = '0;
              inv_d = 1'b0;
            end
          end else begin
            state_d = CALC;
            cnt_d   = CW'(N - 1);
            rad_d   = rad_init;
            rem_d   = '0;
            root_d  = '0;
            // B is odd, so (exp + B - odd) is always even and fits in E_DW+1 bits.
            exp_d   = E_DW'(({1'b0, extExp_op_i} + BIAS_W - {{E_DW{1'b0}}, odd}) >> 1);
          end
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_step;
        root_d = root_step;
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          s_d     = 1'b0;
          e_d     = exp_q;
          f_d     = {root_step, |rem_step};
          rnd_d   = 1'b1;
          inv_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
      rnd_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      rnd_q   <= rnd_d;
      inv_q   <= inv_d;
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign s_res_o     = s_q;
  assign e_res_o     = e_q;
  assign f_res_o     = f_q;
  assign isToRound_o = rnd_q;
  assign invalid_o   = inv_q;

endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// Directed self-checking bench for lamp_fpu_sqrt_iter at default widths (E_DW=8, F_DW=7).
// Expected values are hand-computed roots of the test operands.
module tb_lamp_fpu_sqrt_iter;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        signum_op_i;
  logic [7:0]  extExp_op_i;
  logic [7:0]  extMant_op_i;
  logic        isInf_op_i;
  logic        isZero_op_i;
  logic        isSNAN_op_i;
  logic        isQNAN_op_i;
  logic        valid_o;
  logic        ready_i;
  logic        s_res_o;
  logic [7:0]  e_res_o;
  logic [10:0] f_res_o;
  logic        isToRound_o;
  logic        invalid_o;

  int passed;
  int failed;
  int total;
  int lat;

  lamp_fpu_sqrt_iter #(.E_DW(8), .F_DW(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .signum_op_i  (signum_op_i),
    .extExp_op_i  (extExp_op_i),
    .extMant_op_i (extMant_op_i),
    .isInf_op_i   (isInf_op_i),
    .isZero_op_i  (isZero_op_i),
    .isSNAN_op_i  (isSNAN_op_i),
    .isQNAN_op_i  (isQNAN_op_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .s_res_o      (s_res_o),
    .e_res_o      (e_res_o),
    .f_res_o      (f_res_o),
    .isToRound_o  (isToRound_o),
    .invalid_o    (invalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Presents one operand at a negedge, lets the posedge accept it, drops valid at the next negedge.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [7:0] m,
                               input logic inf, input logic zero, input logic snan, input logic qnan);
    @(negedge clk);
    checkOutput("ready_before_accept", {31'd0, ready_o}, 32'd1);
    signum_op_i  = s;
    extExp_op_i  = e;
    extMant_op_i = m;
    isInf_op_i   = inf;
    isZero_op_i  = zero;
    isSNAN_op_i  = snan;
    isQNAN_op_i  = qnan;
    valid_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 1;
    while (!valid_o && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic releaseResult();
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    checkOutput("valid_after_release", {31'd0, valid_o}, 32'd0);
    checkOutput("ready_after_release", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic checkResult(input string tag, input int explat, input logic s, input logic [7:0] e,
                             input logic [10:0] f, input logic rnd, input logic inv);
    waitResult(lat);
    checkOutput({tag, "_latency"}, lat, explat);
    checkOutput({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    checkOutput({tag, "_s"}, {31'd0, s_res_o}, {31'd0, s});
    checkOutput({tag, "_e"}, {24'd0, e_res_o}, {24'd0, e});
    checkOutput({tag, "_f"}, {21'd0, f_res_o}, {21'd0, f});
    checkOutput({tag, "_round"}, {31'd0, isToRound_o}, {31'd0, rnd});
    checkOutput({tag, "_invalid"}, {31'd0, invalid_o}, {31'd0, inv});
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    signum_op_i = 1'b0; extExp_op_i = 8'd0; extMant_op_i = 8'd0;
    isInf_op_i = 1'b0; isZero_op_i = 1'b0; isSNAN_op_i = 1'b0; isQNAN_op_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_e", {24'd0, e_res_o}, 32'd0);
    checkOutput("reset_f", {21'd0, f_res_o}, 32'd0);
    checkOutput("reset_round", {31'd0, isToRound_o}, 32'd0);
    checkOutput("reset_invalid", {31'd0, invalid_o}, 32'd0);

    // sqrt(4.0) = 2.0
    applyStimulus(1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("four", 11, 1'b0, 8'd128, 11'b1_0000000_000, 1'b1, 1'b0);
    releaseResult();

    // sqrt(2.0) = 1.0110101000001..., sticky from nonzero remainder
    applyStimulus(1'b0, 8'd128, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("two", 11, 1'b0, 8'd127, 11'b1_0110101_001, 1'b1, 1'b0);
    releaseResult();

    // sqrt(2.25) = 1.5 exactly
    applyStimulus(1'b0, 8'd128, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("twoq", 11, 1'b0, 8'd127, 11'b1_1000000_000, 1'b1, 1'b0);
    releaseResult();

    // sqrt(1.0) = 1.0
    applyStimulus(1'b0, 8'd127, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("one", 11, 1'b0, 8'd127, 11'b1_0000000_000, 1'b1, 1'b0);
    releaseResult();

    applyStimulus(1'b1, 8'd127, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("negone", 1, 1'b0, 8'hFF, 11'b11000000000, 1'b0, 1'b1);
    releaseResult();

    applyStimulus(1'b1, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkResult("negzero", 1, 1'b1, 8'd0, 11'd0, 1'b0, 1'b0);
    releaseResult();

    applyStimulus(1'b1, 8'hFF, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkResult("snan", 1, 1'b0, 8'hFF, 11'b11000000000, 1'b0, 1'b1);
    releaseResult();

    applyStimulus(1'b0, 8'hFF, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkResult("qnan", 1, 1'b0, 8'hFF, 11'b11000000000, 1'b0, 1'b0);
    releaseResult();

    applyStimulus(1'b0, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    checkResult("posinf", 1, 1'b0, 8'hFF, 11'd0, 1'b0, 1'b0);
    releaseResult();

    applyStimulus(1'b1, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    checkResult("neginf", 1, 1'b0, 8'hFF, 11'b11000000000, 1'b0, 1'b1);
    releaseResult();

    // Backpressure: hold the sqrt(2.0) result for 5 cycles while a stray operand is offered
    applyStimulus(1'b0, 8'd128, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("bp", 11, 1'b0, 8'd127, 11'b1_0110101_001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        signum_op_i = 1'b0; extExp_op_i = 8'd129; extMant_op_i = 8'h80;
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
      checkOutput("bp_hold_valid", {31'd0, valid_o}, 32'd1);
      checkOutput("bp_hold_ready", {31'd0, ready_o}, 32'd0);
      checkOutput("bp_hold_e", {24'd0, e_res_o}, 32'd127);
      checkOutput("bp_hold_f", {21'd0, f_res_o}, {21'd0, 11'b1_0110101_001});
    end
    valid_i = 1'b0;
    releaseResult();
    applyStimulus(1'b0, 8'd128, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("bp_next", 11, 1'b0, 8'd127, 11'b1_1000000_000, 1'b1, 1'b0);
    releaseResult();

    // Reset in the middle of a calculation abandons it
    applyStimulus(1'b0, 8'd128, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("midrst_e", {24'd0, e_res_o}, 32'd0);
    checkOutput("midrst_f", {21'd0, f_res_o}, 32'd0);
    checkOutput("midrst_round", {31'd0, isToRound_o}, 32'd0);
    checkOutput("midrst_invalid", {31'd0, invalid_o}, 32'd0);
    applyStimulus(1'b0, 8'd129, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResult("postrst", 11, 1'b0, 8'd128, 11'b1_0000000_000, 1'b1, 1'b0);
    releaseResult();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
